// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the multiplexed seven-segment driver.
// Segment codes are active-high {g,f,e,d,c,b,a}; pin polarity is applied at the top.
// Also holds the legal parameter ranges so every user checks them the same way.
package seven_seg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONV   = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    localparam int DIGITS_MIN = 1;
    localparam int DIGITS_MAX = 8;
    localparam int DATA_W_MIN = 1;
    localparam int DATA_W_MAX = 27;

    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Active-high segment pattern for one hex nibble.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] code;
        code = SEG_BLANK;
        case (nib)
            4'h0: code = 7'h3F;
            4'h1: code = 7'h06;
            4'h2: code = 7'h5B;
            4'h3: code = 7'h4F;
            4'h4: code = 7'h66;
            4'h5: code = 7'h6D;
            4'h6: code = 7'h7D;
            4'h7: code = 7'h07;
            4'h8: code = 7'h7F;
            4'h9: code = 7'h6F;
            4'hA: code = 7'h77;
            4'hB: code = 7'h7C;
            4'hC: code = 7'h39;
            4'hD: code = 7'h5E;
            4'hE: code = 7'h79;
            4'hF: code = 7'h71;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

    function automatic bit params_ok(input int digits, input int data_w);
        return (digits >= DIGITS_MIN) && (digits <= DIGITS_MAX) &&
               (data_w >= DATA_W_MIN) && (data_w <= DATA_W_MAX);
    endfunction

endpackage

// File: rtl/seven_seg_bin2bcd_seq.sv
// Sequential double-dabble binary to BCD converter, one input bit per cycle, MSB first.
// Latency: start sampled at edge k, shifts on edges k+1..k+DATA_W, done_o high during the last.
// No backpressure: a start while running restarts the conversion; bcd_o holds until next start.
module bin2bcd_seq
    import seven_seg_pkg::*;
#(
    parameter int DATA_W     = 14,
    parameter int BCD_DIGITS = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start_i,
    input  logic [DATA_W-1:0]            bin_i,
    output logic [BCD_DIGITS-1:0][3:0]   bcd_o,
    output logic                         done_o
);

    localparam int BCD_W = 4 * BCD_DIGITS;
    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0]          bin_q;
    logic [BCD_DIGITS-1:0][3:0] bcd_q;
    logic [BCD_DIGITS-1:0][3:0] adj;
    logic [CNT_W-1:0]           cnt_q;
    logic                       run_q;

    // Add-3 correction on every BCD digit that would reach 10 or more after the shift.
    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            adj[i] = (bcd_q[i] >= 4'd5) ? bcd_q[i] + 4'd3 : bcd_q[i];
        end
    end

    // Shift register and bit counter; carries out of the top BCD digit are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (start_i) begin
            bin_q <= bin_i;
            bcd_q <= '0;
            cnt_q <= CNT_W'(DATA_W);
            run_q <= 1'b1;
        end else if (run_q) begin
            bcd_q <= BCD_W'({adj, bin_q[DATA_W-1]});
            bin_q <= bin_q << 1;
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                run_q <= 1'b0;
            end
        end
    end

    assign done_o = run_q && (cnt_q == CNT_W'(1));
    assign bcd_o  = bcd_q;

endmodule

// File: rtl/seven_seg_mux.sv
// Multi-digit seven-segment driver: captured value to BCD/hex, time-multiplexed onto shared segments.
// Latency: busy for DATA_W cycles (decimal) or 1 (hex); new frame on pins one cycle after busy drops.
// Loads arriving outside IDLE are dropped, never queued; the scan runs freely and is never stalled.
module seven_seg_mux
    import seven_seg_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int DATA_W      = 14,
    parameter int CLK_HZ      = 12_000_000,
    parameter int REFRESH_HZ  = 1000,
    parameter bit SEG_ACT_LOW = 1'b1,
    parameter bit DIG_ACT_LOW = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] value,
    input  logic              load,
    input  logic              hex_mode,
    input  logic              blank_lz,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] dig,
    output logic              busy,
    output logic              overflow
);

    if (!params_ok(DIGITS, DATA_W)) begin : g_param_err
        $error("seven_seg_mux: DIGITS or DATA_W out of range");
    end

    localparam int TICK_RAW = CLK_HZ / REFRESH_HZ;
    localparam int TICK     = (TICK_RAW < 2) ? 2 : TICK_RAW;
    localparam int CNT_W    = $clog2(TICK);
    localparam int IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int HEX_W    = 4 * DIGITS;

    localparam logic [63:0]       DEC_MAX = 64'(10 ** DIGITS) - 64'd1;
    localparam logic [6:0]        SEG_OFF = {7{SEG_ACT_LOW}};
    localparam logic [DIGITS-1:0] DIG_OFF = {DIGITS{DIG_ACT_LOW}};

    state_e                     state_q, state_d;
    logic                       accept;
    logic                       commit;
    logic [DATA_W-1:0]          value_q;
    logic                       hex_q;
    logic                       blz_q;
    logic                       busy_q;
    logic                       ovf_q;
    logic                       ovf_d;
    logic [DIGITS-1:0][6:0]     disp_q, disp_d;
    logic [DIGITS-1:0][3:0]     bcd;
    logic [DIGITS-1:0][3:0]     hex_dig;
    logic [DIGITS-1:0][3:0]     nib;
    logic                       conv_done;
    logic [CNT_W-1:0]           cnt_q;
    logic [IDX_W-1:0]           idx_q;
    logic [6:0]                 seg_q;
    logic [DIGITS-1:0]          dig_q;
    logic [DIGITS-1:0]          dig_act;

    bin2bcd_seq #(
        .DATA_W     (DATA_W),
        .BCD_DIGITS (DIGITS)
    ) u_bin2bcd (
        .clk     (clk),
        .rst     (rst),
        .start_i (accept && !hex_mode),
        .bin_i   (value),
        .bcd_o   (bcd),
        .done_o  (conv_done)
    );

    // Conversion sequencer: capture in IDLE, wait for the converter, publish in COMMIT.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        commit  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (load) begin
                    accept  = 1'b1;
                    state_d = ST_CONV;
                end
            end
            ST_CONV: begin
                if (hex_q || conv_done) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                commit  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state, captured request and status flags. busy lags the FSM by one cycle so it
    // covers exactly the conversion cycles and drops together with the new frame appearing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            value_q <= '0;
            hex_q   <= 1'b0;
            blz_q   <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_q == ST_CONV);
            if (accept) begin
                value_q <= value;
                hex_q   <= hex_mode;
                blz_q   <= blank_lz;
            end
            if (commit) begin
                ovf_q <= ovf_d;
            end
        end
    end

    if (DATA_W >= HEX_W) begin : g_hex_trunc
        assign hex_dig = value_q[HEX_W-1:0];
    end else begin : g_hex_ext
        assign hex_dig = {{(HEX_W - DATA_W){1'b0}}, value_q};
    end

    assign ovf_d = hex_q ? ((64'(value_q) >> HEX_W) != 64'd0)
                         : (64'(value_q) > DEC_MAX);
    assign nib   = hex_q ? hex_dig : bcd;

    // Candidate frame: dashes on overflow, else digits with optional leading-zero blanking.
    always_comb begin
        logic seen;
        seen   = 1'b0;
        disp_d = disp_q;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            seen = seen || (nib[i] != 4'd0) || (i == 0);
            if (ovf_d) begin
                disp_d[i] = SEG_DASH;
            end else if (blz_q && !seen) begin
                disp_d[i] = SEG_BLANK;
            end else begin
                disp_d[i] = seg_decode(nib[i]);
            end
        end
    end

    // Display register: only COMMIT replaces it, so the old frame stays up during conversion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_q <= '0;
        end else if (commit) begin
            disp_q <= disp_d;
        end
    end

    // Scan prescaler and digit index; free-running, independent of the conversion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else if (cnt_q == CNT_W'(TICK - 1)) begin
            cnt_q <= '0;
            idx_q <= (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // All enables off in the slot's first cycle so the segment change cannot ghost.
    assign dig_act = (cnt_q == '0) ? '0 : (DIGITS'(1) << idx_q);

    // Registered pin drivers with polarity applied.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q <= SEG_OFF;
            dig_q <= DIG_OFF;
        end else begin
            seg_q <= disp_q[idx_q] ^ SEG_OFF;
            dig_q <= dig_act ^ DIG_OFF;
        end
    end

    assign seg      = seg_q;
    assign dig      = dig_q;
    assign busy     = busy_q;
    assign overflow = ovf_q;

endmodule

// File: doc/seven_seg_mux.md
# seven_seg_mux

Parametrised multi-digit seven-segment display driver: captures a binary value on a load strobe, converts it sequentially to BCD (or splits it into hex nibbles), and time-multiplexes the digits onto shared segment lines with leading-zero blanking, overflow indication and selectable output polarity. It sits between board-level logic (switches, counters) and the display pins, replacing the fixed 8-bit single-mode display path.

## Interface
- `DIGITS`, 4: number of digits (1..8); digit 0 is the rightmost, least significant.
- `DATA_W`, 14: width of `value` (1..27).
- `CLK_HZ`, 12_000_000: `clk` frequency.
- `REFRESH_HZ`, 1000: per-digit switch rate; `TICK = CLK_HZ/REFRESH_HZ` cycles per digit, minimum 2.
- `SEG_ACT_LOW`, 1: segment outputs active low.
- `DIG_ACT_LOW`, 1: digit enables active low.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, asynchronous, active-high.
- `value` in DATA_W: binary value to display.
- `load` in 1: one-cycle capture strobe for `value`, `hex_mode`, `blank_lz`.
- `hex_mode` in 1: 1 = hexadecimal, 0 = decimal.
- `blank_lz` in 1: 1 = blank leading zeros.
- `seg` out 7: {g,f,e,d,c,b,a}.
- `dig` out DIGITS: one-hot digit enable.
- `busy` out 1: conversion in progress.
- `overflow` out 1: last committed value did not fit in `DIGITS` digits.

## Operation
- FSM `IDLE -> CONV -> COMMIT -> IDLE`. `load` sampled in IDLE only; `load` while `busy` ignored, no queueing.
- Decimal: shift-add-3 double dabble, one bit per cycle, MSB first, DATA_W cycles in CONV. Hex: CONV lasts one cycle (direct nibble split).
- Overflow: decimal if `value > 10**DIGITS - 1`; hex if `value >> 4*DIGITS != 0`. On overflow every digit shows dash, `overflow`=1; otherwise `overflow`=0.
- Double-buffered: display register changes only in COMMIT; old content displayed throughout CONV.
- Active-high codes 0..F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71; dash 40; blank 00. Inverted at pins when `*_ACT_LOW`.
- Leading-zero blanking (captured `blank_lz`=1): every digit above the most significant nonzero digit shows blank; digit 0 never blanked (value 0 shows "0"). Not applied to dashes.
- Multiplex: prescaler counts 0..TICK-1; on wrap, digit index increments, DIGITS-1 wraps to 0. Exactly one `dig` bit active, except the first cycle of each digit slot, where all digits are inactive (ghost suppression).
- Until the first COMMIT after reset, all digits display blank.

## Timing
- Reset values: `seg` all inactive, `dig` all inactive, `busy`=0, `overflow`=0, index 0, prescaler 0, display register blank.
- `load` sampled at edge k: `busy`=1 from k+1; decimal CONV k+1..k+DATA_W, COMMIT k+DATA_W+1; hex CONV k+1, COMMIT k+2. `busy` falls and new content/`overflow` visible in the edge after COMMIT. `load` accepted again in the cycle `busy` is 0.
- `seg`, `dig` registered: change one cycle after the prescaler wrap.
- `load` coincident with a digit switch: both proceed independently.
- `rst` mid-conversion: FSM to IDLE, partial result discarded, display blank.

## Structure
- Package `seven_seg_pkg`: state enum, segment code constants (digits, dash, blank), `seg_decode(nibble)` function, `DIGITS`/`DATA_W` range checks.
- Sub-module `bin2bcd_seq`: start/done sequential double dabble, parametrised by `DATA_W` and BCD digit count; owns the shift register. Top owns FSM, overflow, display register, prescaler, mux, polarity.

## Test plan
Bench parameters: DIGITS=4, DATA_W=14, CLK_HZ=1000, REFRESH_HZ=100 (TICK=10).
- Reset, no load -> `dig` inactive first cycle of each slot, otherwise one-hot cycling 0..3 every 10 cycles; `seg` = blank (7F pins, active low) on all digits; `busy`=0.
- Load 1234 decimal, `blank_lz`=0 -> `busy` high exactly 14 cycles, then digits 3..0 show 06 5B 4F 66 (active-high), `overflow`=0.
- Load 7 decimal, `blank_lz`=1 -> digits 3..1 blank, digit 0 = 07; load 0 -> only digit 0 shows 3F.
- Load 10000 decimal -> all digits 40, `overflow`=1; then 9999 -> 6F on all, `overflow`=0.
- Load 0x2BEF hex -> `busy` 1 cycle; digits 5B 7C 79 71; second `load` during a decimal conversion ignored (display unchanged by it).
- Assert `rst` halfway through a decimal conversion -> outputs return to reset values, next load converts correctly.
